// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder
// Brief    : TMDS 8b/10b channel encoder, two-stage pipeline with running
//            disparity. Optional raw-symbol bypass enabled by TMDS_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
module tmds_encoder #(
    parameter int PIPE_BLANK = 1
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic [1:0] ctl,
    input  logic       blank,
`ifdef TMDS_BYPASS_EN
    input  logic       raw_en,
    input  logic [9:0] raw_sym,
`endif
    output logic [9:0] tmds
);

    localparam logic [9:0] c_SYM_CTL00 = 10'b1101010100;
    localparam logic [9:0] c_SYM_CTL01 = 10'b0010101011;
    localparam logic [9:0] c_SYM_CTL10 = 10'b0101010100;
    localparam logic [9:0] c_SYM_CTL11 = 10'b1010101011;

    logic [3:0]        w_n1d;
    logic              w_use_xnor;
    logic [8:0]        w_qm;
    logic [8:0]        r_qm;
    logic              w_blank_s2;
    logic [1:0]        w_ctl_s2;
    logic [3:0]        w_n1q;
    logic signed [5:0] w_disp;
    logic signed [5:0] w_cnt_next;
    logic signed [5:0] r_cnt;
    logic [9:0]        w_sym;
    logic [9:0]        r_tmds;

    // Stage 1: transition-minimising XOR/XNOR chain
    always_comb begin
        w_n1d = '0;
        for (int i = 0; i < 8; i++) begin
            w_n1d = w_n1d + {3'b000, data[i]};
        end
        w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !data[0]);
        w_qm       = '0;
        w_qm[0]    = data[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ data[i]) : (w_qm[i-1] ^ data[i]);
        end
        w_qm[8] = ~w_use_xnor;
    end

    generate
        if (PIPE_BLANK != 0) begin : g_pipe_blank
            logic       r_blank_d1;
            logic [1:0] r_ctl_d1;

            always_ff @(posedge pixel_clock) begin
                if (reset) begin
                    r_blank_d1 <= 1'b1;
                    r_ctl_d1   <= 2'b00;
                end else begin
                    r_blank_d1 <= blank;
                    r_ctl_d1   <= ctl;
                end
            end

            assign w_blank_s2 = r_blank_d1;
            assign w_ctl_s2   = r_ctl_d1;
        end else begin : g_no_pipe_blank
            // Caller already aligned blank/ctl with the stage-2 data
            assign w_blank_s2 = blank;
            assign w_ctl_s2   = ctl;
        end
    endgenerate

`ifdef TMDS_BYPASS_EN
    logic       r_raw_en_d1;
    logic [9:0] r_raw_sym_d1;

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_raw_en_d1  <= 1'b0;
            r_raw_sym_d1 <= '0;
        end else begin
            r_raw_en_d1  <= raw_en;
            r_raw_sym_d1 <= raw_sym;
        end
    end
`endif

    // Stage 2: DC-balance selection; w_disp = n1q - n0q = 2*n1q - 8
    always_comb begin
        w_n1q = '0;
        for (int i = 0; i < 8; i++) begin
            w_n1q = w_n1q + {3'b000, r_qm[i]};
        end
        w_disp = $signed({1'b0, w_n1q, 1'b0}) - 6'sd8;

        if ((r_cnt == 6'sd0) || (w_n1q == 4'd4)) begin
            w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_next = r_qm[8] ? (r_cnt + w_disp) : (r_cnt - w_disp);
        end else if ((!r_cnt[5] && (w_n1q > 4'd4)) || (r_cnt[5] && (w_n1q < 4'd4))) begin
            w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next = r_cnt - w_disp + (r_qm[8] ? 6'sd2 : 6'sd0);
        end else begin
            w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next = r_cnt + w_disp - (r_qm[8] ? 6'sd0 : 6'sd2);
        end

        if (w_blank_s2) begin
            case (w_ctl_s2)
                2'b00:   w_sym = c_SYM_CTL00;
                2'b01:   w_sym = c_SYM_CTL01;
                2'b10:   w_sym = c_SYM_CTL10;
                default: w_sym = c_SYM_CTL11;
            endcase
            w_cnt_next = '0;
        end

`ifdef TMDS_BYPASS_EN
        // Raw symbols win over everything and leave the disparity untouched
        if (r_raw_en_d1) begin
            w_sym      = r_raw_sym_d1;
            w_cnt_next = r_cnt;
        end
`endif
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_qm   <= '0;
            r_tmds <= c_SYM_CTL00;
            r_cnt  <= '0;
        end else begin
            r_qm   <= w_qm;
            r_tmds <= w_sym;
            r_cnt  <= w_cnt_next;
        end
    end

    assign tmds = r_tmds;

endmodule
`default_nettype wire
